ahb_uart_tx: RTL

//  AHB-Lite slave: memory-mapped UART transmitter on one decoded slot of the bus controller.

---
 rtl/ahb_uart_tx_if.sv | 24 ++
 rtl/ahb_uart_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_uart_tx_if.sv
// Slave-side AHB-Lite signals of one decoded bus slot.
// The bus controller drives the address/data-phase inputs; the slave returns rdata/ready_out/resp.
interface ahb_uart_tx_if;
  logic        sel;
  logic [31:0] addr;
  logic        write;
  logic [1:0]  trans;
  logic [2:0]  size;
  logic [31:0] wdata;
  logic        ready_in;
  logic [31:0] rdata;
  logic        ready_out;
  logic        resp;

  modport master (
    output sel, addr, write, trans, size, wdata, ready_in,
    input  rdata, ready_out, resp
  );

  modport slave (
    input  sel, addr, write, trans, size, wdata, ready_in,
    output rdata, ready_out, resp
  );
endinterface

// File: rtl/ahb_uart_tx.sv
// Memory-mapped UART transmitter on an AHB-Lite slot.
// Writes to DATA are queued in a circular FIFO and sent as 8N1 frames on txd,
// each bit lasting DIV clock cycles (DIV latched per frame, 0 treated as 1).
module ahb_uart_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic           clk,
  input  logic           rst,
  ahb_uart_tx_if.slave   bus,
  output logic           txd,
  output logic           irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  typedef logic [AW:0] ptr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Bus pipeline and configuration registers
  logic        dp_valid_reg;
  logic        dp_write_reg;
  logic [1:0]  dp_idx_reg;
  logic        err2_reg;
  logic [15:0] div_cfg_reg;
  logic        en_reg;

  // FIFO
  logic [7:0]  mem [FIFO_DEPTH];
  ptr_t        wr_ptr_reg;
  ptr_t        rd_ptr_reg;
  ptr_t        count;
  logic        full;
  logic        empty;

  // Transmitter
  state_t      state_reg, state_next;
  logic [15:0] bit_div_reg, bit_div_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic        txd_reg, txd_next;
  logic        pop;
  logic        tx_busy;
  logic        bit_last;

  // Bus-side decode
  logic        err_now;
  logic        accept;
  logic        wr_ok;
  logic        push;
  logic [31:0] rdata_int;

  // Only addr[3:2] is decoded and size is ignored; the remaining bits are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{bus.size, bus.trans[0], bus.addr[31:4], bus.addr[1:0], bus.wdata[31:16]};

  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (count == ptr_t'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign tx_busy = (state_reg != ST_IDLE);
  assign irq     = en_reg & empty & ~tx_busy;
  assign txd     = txd_reg;

  // Data-phase decode: error detection, address-phase acceptance, read mux
  always_comb begin
    err_now   = 1'b0;
    rdata_int = 32'h0;
    if (dp_valid_reg && dp_write_reg)
      err_now = (dp_idx_reg == 2'd1) || ((dp_idx_reg == 2'd0) && full);
    // No new address phase while the first ERROR cycle holds the bus.
    accept = bus.sel & bus.ready_in & bus.trans[1] & ~err_now;
    wr_ok  = dp_valid_reg & dp_write_reg & ~err_now;
    push   = wr_ok & (dp_idx_reg == 2'd0);
    if (dp_valid_reg && !dp_write_reg) begin
      case (dp_idx_reg)
        2'd1:    rdata_int = {29'h0, tx_busy, full, empty};
        2'd2:    rdata_int = {16'h0, div_cfg_reg};
        2'd3:    rdata_int = {31'h0, en_reg};
        default: rdata_int = 32'h0;
      endcase
    end
  end

  assign bus.rdata     = rdata_int;
  assign bus.ready_out = ~err_now;
  assign bus.resp      = err_now | err2_reg;

  // Address-phase capture, two-cycle ERROR tracking and register writes at end of data phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_valid_reg <= 1'b0;
      dp_write_reg <= 1'b0;
      dp_idx_reg   <= 2'd0;
      err2_reg     <= 1'b0;
      div_cfg_reg  <= DIV_RESET;
      en_reg       <= 1'b0;
    end else begin
      dp_valid_reg <= accept;
      if (accept) begin
        dp_write_reg <= bus.write;
        dp_idx_reg   <= bus.addr[3:2];
      end
      err2_reg <= err_now;
      if (wr_ok && dp_idx_reg == 2'd2)
        div_cfg_reg <= bus.wdata[15:0];
      if (wr_ok && dp_idx_reg == 2'd3)
        en_reg <= bus.wdata[0];
    end
  end

  // FIFO pointers; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + ptr_t'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + ptr_t'(1);
    end
  end

  // FIFO storage (no reset; contents are only meaningful between the pointers)
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg[AW-1:0]] <= bus.wdata[7:0];
  end

  // Transmitter state register; txd returns high immediately on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      bit_div_reg <= 16'd1;
      cnt_reg     <= 16'd0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'h0;
      txd_reg     <= 1'b1;
    end else begin
      state_reg   <= state_next;
      bit_div_reg <= bit_div_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      txd_reg     <= txd_next;
    end
  end

  assign bit_last = (cnt_reg == bit_div_reg - 16'd1);

  // Transmitter next-state: each of START, 8 DATA bits and STOP lasts bit_div_reg cycles
  always_comb begin
    state_next   = state_reg;
    bit_div_next = bit_div_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    pop          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (en_reg && !empty) begin
          pop          = 1'b1;
          shift_next   = mem[rd_ptr_reg[AW-1:0]];
          bit_div_next = (div_cfg_reg == 16'd0) ? 16'd1 : div_cfg_reg;
          cnt_next     = 16'd0;
          state_next   = ST_START;
        end
      end
      ST_START: begin
        if (bit_last) begin
          cnt_next     = 16'd0;
          bit_idx_next = 3'd0;
          state_next   = ST_DATA;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_last) begin
          cnt_next   = 16'd0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7)
            state_next = ST_STOP;
          else
            bit_idx_next = bit_idx_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: begin
        if (bit_last) begin
          cnt_next   = 16'd0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
    endcase
    case (state_next)
      ST_START: txd_next = 1'b0;
      ST_DATA:  txd_next = shift_next[0];
      default:  txd_next = 1'b1;
    endcase
  end

endmodule
